// File: rtl/sd_spi_cmd_engine_if.sv
// Command request / response bundle between a card-level FSM (master)
// and the SD SPI command engine (slave).
interface sd_spi_cmd_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  cmd_rtype;
  logic        cmd_hold_cs;
  logic        rsp_valid;
  logic [7:0]  rsp_r1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  modport master (
    output cmd_valid, cmd_index, cmd_arg, cmd_rtype, cmd_hold_cs,
    input  cmd_ready, rsp_valid, rsp_r1, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, cmd_rtype, cmd_hold_cs,
    output cmd_ready, rsp_valid, rsp_r1, rsp_data, rsp_err
  );
endinterface

// File: rtl/sd_spi_cmd_engine.sv
// SD SPI-mode command/response engine: frames CMD+ARG+CRC7, polls R1, collects
// R3/R7 payload or waits out R1b busy, all through a one-byte-in-flight SPI master.
module sd_spi_cmd_engine #(
  parameter int          NCR_MAX   = 16,
  parameter logic [23:0] BUSY_MAX  = 24'd500000,
  parameter int          GAP_BYTES = 1,
  parameter bit          CRC_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  sd_spi_cmd_engine_if.slave cmd,
  output logic               spi_start,
  output logic [7:0]         spi_mosi,
  input  logic               spi_busy,
  input  logic               spi_done,
  input  logic [7:0]         spi_miso,
  output logic               sd_cs_n
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SEND, S_POLL, S_EXT, S_BUSY, S_FIN, S_GAP, S_DONE
  } state_t;

  localparam logic [23:0] NCR_LIM = NCR_MAX[23:0];
  localparam logic [23:0] GAP_LIM = GAP_BYTES[23:0];

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [47:0] frame_q, frame_d;
  logic [1:0]  rtype_q, rtype_d;
  logic        hold_q, hold_d;
  logic [23:0] cnt_q, cnt_d;
  logic        out_q, out_d;
  logic        spi_start_q, spi_start_d;
  logic [7:0]  spi_mosi_q, spi_mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  r1_q, r1_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  err_q, err_d;

  logic        byte_ok;
  logic        byte_rx;
  logic        tx_en;
  logic [7:0]  tx_byte;
  logic [23:0] cnt_inc;
  logic [6:0]  crc_calc;
  logic        crc_on;

  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 24'd1;
  assign crc_calc = crc7({2'b01, cmd.cmd_index, cmd.cmd_arg});
  // CMD0 and CMD8 are checked by the card even in CRC-off mode.
  assign crc_on   = CRC_EN || (cmd.cmd_index == 6'd0) || (cmd.cmd_index == 6'd8);
  assign byte_ok  = !out_q && !spi_busy && !spi_done;
  assign byte_rx  = out_q && spi_done;

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    rtype_d     = rtype_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    spi_start_d = 1'b0;
    spi_mosi_d  = spi_mosi_q;
    cs_n_d      = cs_n_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    r1_d        = r1_q;
    data_d      = data_q;
    err_d       = err_q;
    tx_en       = 1'b0;
    tx_byte     = 8'hFF;

    if (byte_rx) out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          frame_d = {2'b01, cmd.cmd_index, cmd.cmd_arg,
                     crc_on ? {crc_calc, 1'b1} : 8'hFF};
          rtype_d = cmd.cmd_rtype;
          hold_d  = cmd.cmd_hold_cs;
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          r1_d    = 8'hFF;
          data_d  = '0;
          err_d   = 2'd0;
          cnt_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        tx_en = 1'b1;
        if (byte_rx) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_en   = 1'b1;
        tx_byte = frame_q[47:40];
        if (byte_rx) begin
          frame_d = {frame_q[39:0], 8'hFF};
          cnt_d   = cnt_inc;
          if (cnt_q == 24'd5) begin
            cnt_d   = '0;
            state_d = S_POLL;
          end
        end
      end
      S_POLL: begin
        tx_en = 1'b1;
        if (byte_rx) begin
          if (!spi_miso[7]) begin
            r1_d  = spi_miso;
            cnt_d = '0;
            if (spi_miso[2]) begin
              err_d   = 2'd3;
              state_d = S_FIN;
            end else if (rtype_q == 2'd2) begin
              state_d = S_EXT;
            end else if (rtype_q == 2'd1) begin
              state_d = S_BUSY;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= NCR_LIM) begin
              err_d   = 2'd1;
              r1_d    = 8'hFF;
              state_d = S_FIN;
            end
          end
        end
      end
      S_EXT: begin
        tx_en = 1'b1;
        if (byte_rx) begin
          data_d = {data_q[23:0], spi_miso};
          cnt_d  = cnt_inc;
          if (cnt_q == 24'd3) state_d = S_FIN;
        end
      end
      S_BUSY: begin
        tx_en = 1'b1;
        if (byte_rx) begin
          if (spi_miso != 8'h00) begin
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= BUSY_MAX) begin
              err_d   = 2'd2;
              state_d = S_FIN;
            end
          end
        end
      end
      S_FIN: begin
        cnt_d = '0;
        if (hold_q) begin
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cs_n_d = 1'b1;
          if (GAP_LIM == 24'd0) begin
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        tx_en = 1'b1;
        if (byte_rx) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= GAP_LIM) begin
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // byte_ok excludes the spi_done cycle, so a start never overlaps a receive.
    if (tx_en && byte_ok) begin
      spi_start_d = 1'b1;
      spi_mosi_d  = tx_byte;
      out_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      frame_q     <= '1;
      rtype_q     <= 2'd0;
      hold_q      <= 1'b0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      spi_start_q <= 1'b0;
      spi_mosi_q  <= 8'hFF;
      cs_n_q      <= 1'b1;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      r1_q        <= 8'hFF;
      data_q      <= '0;
      err_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      rtype_q     <= rtype_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      spi_start_q <= spi_start_d;
      spi_mosi_q  <= spi_mosi_d;
      cs_n_q      <= cs_n_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      r1_q        <= r1_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign spi_start     = spi_start_q;
  assign spi_mosi      = spi_mosi_q;
  assign sd_cs_n       = cs_n_q;
  assign cmd.cmd_ready = ready_q;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_r1    = r1_q;
  assign cmd.rsp_data  = data_q;
  assign cmd.rsp_err   = err_q;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench: two engines (default and BUSY_MAX=8/no gap/CRC off) share one
// SD card byte model; expected bytes, CRCs and status are hand-computed.
module tb_sd_spi_cmd_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  cmd_rtype;
  logic        cmd_hold_cs;

  logic       spi_busy, spi_done;
  logic [7:0] spi_miso;
  logic       a_start, b_start, a_cs_n, b_cs_n;
  logic [7:0] a_mosi, b_mosi;

  sd_spi_cmd_engine_if if_a ();
  sd_spi_cmd_engine_if if_b ();

  assign if_a.cmd_valid   = cmd_valid && !sel;
  assign if_b.cmd_valid   = cmd_valid && sel;
  assign if_a.cmd_index   = cmd_index;
  assign if_b.cmd_index   = cmd_index;
  assign if_a.cmd_arg     = cmd_arg;
  assign if_b.cmd_arg     = cmd_arg;
  assign if_a.cmd_rtype   = cmd_rtype;
  assign if_b.cmd_rtype   = cmd_rtype;
  assign if_a.cmd_hold_cs = cmd_hold_cs;
  assign if_b.cmd_hold_cs = cmd_hold_cs;

  sd_spi_cmd_engine dut_a (
    .clk(clk), .rst_n(rst_n), .cmd(if_a),
    .spi_start(a_start), .spi_mosi(a_mosi), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_miso(spi_miso), .sd_cs_n(a_cs_n)
  );

  sd_spi_cmd_engine #(.NCR_MAX(16), .BUSY_MAX(24'd8), .GAP_BYTES(0), .CRC_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd(if_b),
    .spi_start(b_start), .spi_mosi(b_mosi), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_miso(spi_miso), .sd_cs_n(b_cs_n)
  );

  logic        m_start, m_cs_n, m_ready, m_rsp_valid;
  logic [7:0]  m_mosi, m_r1;
  logic [31:0] m_data;
  logic [1:0]  m_err;
  assign m_start     = sel ? b_start : a_start;
  assign m_cs_n      = sel ? b_cs_n : a_cs_n;
  assign m_mosi      = sel ? b_mosi : a_mosi;
  assign m_ready     = sel ? if_b.cmd_ready : if_a.cmd_ready;
  assign m_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
  assign m_r1        = sel ? if_b.rsp_r1 : if_a.rsp_r1;
  assign m_data      = sel ? if_b.rsp_data : if_a.rsp_data;
  assign m_err       = sel ? if_b.rsp_err : if_a.rsp_err;

  logic [7:0] resp [0:31];
  int         resp_len;
  int         gen;
  logic [7:0] log_mosi [0:511];
  logic       log_cs [0:511];
  int         nlog = 0;
  int         valid_cnt = 0;
  int         total = 0;
  int         bad = 0;
  int         cur_base, cur_nbytes;

  // Card model: first 7 CS-low bytes of a command get FF, then the response list.
  initial begin : card
    int seen_gen;
    int bidx;
    logic [7:0] r;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_miso = 8'hFF;
    seen_gen = 0;
    bidx     = 0;
    forever begin
      @(negedge clk);
      if (m_start) begin
        if (gen != seen_gen) begin
          seen_gen = gen;
          bidx     = 0;
        end
        if (nlog < 512) begin
          log_mosi[nlog] = m_mosi;
          log_cs[nlog]   = m_cs_n;
        end
        nlog++;
        r = 8'hFF;
        if (!m_cs_n) begin
          if (bidx >= 7 && (bidx - 7) < resp_len) r = resp[bidx - 7];
          bidx++;
        end
        #1 spi_busy = 1'b1;
        repeat (3) @(negedge clk);
        spi_busy = 1'b0;
        spi_done = 1'b1;
        spi_miso = r;
        @(negedge clk);
        spi_done = 1'b0;
      end
    end
  end

  initial begin : valid_mon
    forever begin
      @(negedge clk);
      if (m_rsp_valid) valid_cnt++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_resp(input logic [39:0] v, input int n);
    for (int i = 0; i < n; i++) resp[i] = v[8*(n-1-i) +: 8];
    resp_len = n;
  endtask

  task automatic run_cmd(input logic s, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input logic hold);
    int t;
    int vb;
    sel = s;
    gen++;
    @(negedge clk);
    cur_base    = nlog;
    vb          = valid_cnt;
    cmd_index   = idx;
    cmd_arg     = arg;
    cmd_rtype   = rt;
    cmd_hold_cs = hold;
    t = 0;
    while (!m_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before", 32'(m_ready), 32'd1);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    t = 0;
    while (!m_rsp_valid && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_seen", 32'(m_rsp_valid), 32'd1);
    chk("ready_low_at_valid", 32'(m_ready), 32'd0);
    repeat (3) @(negedge clk);
    cur_nbytes = nlog - cur_base;
    chk("one_valid", 32'(valid_cnt - vb), 32'd1);
    chk("ready_back", 32'(m_ready), 32'd1);
    $display("cmd%0d dut=%0d r1=%h err=%0d data=%h bytes=%0d cs_n=%b",
             idx, s, m_r1, m_err, m_data, cur_nbytes, m_cs_n);
  endtask

  task automatic expect_rsp(input logic chk_crc, input logic [7:0] crc, input logic [7:0] r1,
                            input logic [1:0] err, input logic [31:0] data, input int nb);
    if (chk_crc) chk("crc_byte", 32'(log_mosi[cur_base + 6]), 32'(crc));
    chk("r1", 32'(m_r1), 32'(r1));
    chk("err", 32'(m_err), 32'(err));
    chk("data", m_data, data);
    chk("nbytes", 32'(cur_nbytes), 32'(nb));
  endtask

  initial begin : main
    int t;
    int vb;
    int nb;
    sel = 1'b0; gen = 0; resp_len = 0;
    cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_rtype = '0; cmd_hold_cs = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(a_cs_n), 32'd1);
    chk("rst_start", 32'(a_start), 32'd0);
    chk("rst_mosi", 32'(a_mosi), 32'hFF);
    chk("rst_ready", 32'(if_a.cmd_ready), 32'd1);
    chk("rst_valid", 32'(if_a.rsp_valid), 32'd0);
    chk("rst_r1", 32'(if_a.rsp_r1), 32'hFF);
    chk("rst_data", if_a.rsp_data, 32'h0);
    chk("rst_err", 32'(if_a.rsp_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0: FF FF 01 -> 1 pre + 6 cmd + 3 poll + 1 gap
    set_resp(40'hFFFF01, 3);
    run_cmd(1'b0, 6'd0, 32'h0, 2'd0, 1'b0);
    expect_rsp(1'b1, 8'h95, 8'h01, 2'd0, 32'h0, 11);
    chk("cmd0_pre", 32'(log_mosi[cur_base]), 32'hFF);
    chk("cmd0_pre_cs", 32'(log_cs[cur_base]), 32'd0);
    chk("cmd0_b1", 32'(log_mosi[cur_base + 1]), 32'h40);
    chk("cmd0_b2", 32'(log_mosi[cur_base + 2]), 32'h00);
    chk("cmd0_b5", 32'(log_mosi[cur_base + 5]), 32'h00);
    chk("cmd0_poll", 32'(log_mosi[cur_base + 9]), 32'hFF);
    chk("cmd0_gap_cs", 32'(log_cs[cur_base + 10]), 32'd1);
    chk("cmd0_cs_end", 32'(a_cs_n), 32'd1);

    set_resp(40'h01000001AA, 5);
    run_cmd(1'b0, 6'd8, 32'h000001AA, 2'd2, 1'b0);
    expect_rsp(1'b1, 8'h87, 8'h01, 2'd0, 32'h000001AA, 13);
    chk("cmd8_b4", 32'(log_mosi[cur_base + 4]), 32'h01);

    set_resp(40'h01, 1);
    run_cmd(1'b0, 6'd55, 32'h0, 2'd0, 1'b0);
    expect_rsp(1'b1, 8'h65, 8'h01, 2'd0, 32'h0, 9);

    set_resp(40'h00, 1);
    run_cmd(1'b0, 6'd41, 32'h40000000, 2'd0, 1'b0);
    expect_rsp(1'b1, 8'h77, 8'h00, 2'd0, 32'h0, 9);
    chk("acmd41_b2", 32'(log_mosi[cur_base + 2]), 32'h40);

    set_resp(40'h00C0FF8000, 5);
    run_cmd(1'b0, 6'd58, 32'h0, 2'd2, 1'b0);
    expect_rsp(1'b1, 8'hFD, 8'h00, 2'd0, 32'hC0FF8000, 13);

    set_resp(40'h00, 1);
    run_cmd(1'b0, 6'd16, 32'h00000200, 2'd0, 1'b0);
    expect_rsp(1'b1, 8'h15, 8'h00, 2'd0, 32'h0, 9);

    // Illegal command: no payload bytes, data cleared from the previous R3
    set_resp(40'h01000001AA, 5);
    run_cmd(1'b0, 6'd8, 32'h000001AA, 2'd2, 1'b0);
    set_resp(40'h05, 1);
    run_cmd(1'b0, 6'd8, 32'h000001AA, 2'd2, 1'b0);
    expect_rsp(1'b1, 8'h87, 8'h05, 2'd3, 32'h0, 9);

    // No answer: 16 polls then timeout
    resp_len = 0;
    run_cmd(1'b0, 6'd1, 32'h0, 2'd0, 1'b0);
    expect_rsp(1'b0, 8'h00, 8'hFF, 2'd1, 32'h0, 24);
    chk("ncr_cs_end", 32'(a_cs_n), 32'd1);

    // R1b: R1=00, 20 busy zeros, then FF -> 21 busy bytes
    for (int i = 0; i < 21; i++) resp[i] = 8'h00;
    resp[21] = 8'hFF;
    resp_len = 22;
    run_cmd(1'b0, 6'd12, 32'h0, 2'd1, 1'b0);
    expect_rsp(1'b0, 8'h00, 8'h00, 2'd0, 32'h0, 30);

    // Second engine: busy timeout after 8 bytes, no gap byte
    resp_len = 21;
    run_cmd(1'b1, 6'd12, 32'h0, 2'd1, 1'b0);
    expect_rsp(1'b0, 8'h00, 8'h00, 2'd2, 32'h0, 16);
    chk("b_busy_cs_end", 32'(b_cs_n), 32'd1);

    // CRC disabled: CMD55 gets FF, CMD8 still computed
    set_resp(40'h01, 1);
    run_cmd(1'b1, 6'd55, 32'h0, 2'd0, 1'b0);
    expect_rsp(1'b1, 8'hFF, 8'h01, 2'd0, 32'h0, 8);
    set_resp(40'h01000001AA, 5);
    run_cmd(1'b1, 6'd8, 32'h000001AA, 2'd2, 1'b0);
    expect_rsp(1'b1, 8'h87, 8'h01, 2'd0, 32'h000001AA, 12);

    // CS held low for a following data phase
    set_resp(40'h00, 1);
    run_cmd(1'b0, 6'd17, 32'h0, 2'd0, 1'b1);
    expect_rsp(1'b0, 8'h00, 8'h00, 2'd0, 32'h0, 8);
    chk("hold_cs_low", 32'(a_cs_n), 32'd0);

    // Asynchronous reset in the middle of the command frame
    sel = 1'b0;
    gen++;
    resp_len = 0;
    @(negedge clk);
    cur_base    = nlog;
    vb          = valid_cnt;
    cmd_index   = 6'd17;
    cmd_arg     = 32'h0;
    cmd_rtype   = 2'd0;
    cmd_hold_cs = 1'b0;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    t = 0;
    while ((nlog - cur_base) < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach_send", 32'((nlog - cur_base) >= 3), 32'd1);
    chk("rst_pre_cs", 32'(a_cs_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", 32'(a_cs_n), 32'd1);
    chk("arst_start", 32'(a_start), 32'd0);
    chk("arst_ready", 32'(if_a.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    nb = nlog;
    repeat (50) @(negedge clk);
    chk("arst_no_valid", 32'(valid_cnt - vb), 32'd0);
    chk("arst_no_bytes", 32'(nlog - nb), 32'd0);
    chk("arst_ready_after", 32'(if_a.cmd_ready), 32'd1);
    chk("arst_cs_after", 32'(a_cs_n), 32'd1);
    chk("arst_r1", 32'(if_a.rsp_r1), 32'hFF);
    $display("reset mid-send: cs_n=%b ready=%b", a_cs_n, if_a.cmd_ready);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sd_spi_cmd_engine.md
Name: sd_spi_cmd_engine

Overview:
Generic SD SPI-mode command/response engine: accepts one command request (index, argument, response type), frames the 6-byte packet with a computed CRC7 and drives it through the shared SPI byte engine. It polls for R1, collects an optional 32-bit R3/R7 payload, waits out R1b busy and reports status with a bounded timeout on every wait. It sits between the init sequencer and block read/write FSMs, and the SPI byte master (spi_div is owned elsewhere).

Parameters:
NCR_MAX, 16, max 0xFF poll bytes after the command before an R1 timeout.
BUSY_MAX, 24'd500000, max poll bytes in R1b busy before a busy timeout.
GAP_BYTES, 1, 0xFF bytes sent with CS high after a command that releases CS.
CRC_EN, 1, 1 = computed CRC7; 0 = CRC byte forced to 8'hFF, except CMD0 (95) and CMD8 (87), which are always computed.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  request valid
cmd_ready  out  1  engine idle, request accepted when valid&&ready
cmd_index  in  6  command index (byte0 = {2'b01, index})
cmd_arg  in  32  argument, MSB byte first
cmd_rtype  in  2  0 = R1, 1 = R1b, 2 = R3/R7 (R1 + 4 bytes), 3 = reserved (treated as R1)
cmd_hold_cs  in  1  1 = keep CS low after the response (data phase follows)
rsp_valid  out  1  one-cycle pulse with the result
rsp_r1  out  8  R1 byte (8'hFF on timeout)
rsp_data  out  32  R3/R7 payload, first received byte in [31:24]; 0 when not collected
rsp_err  out  2  0 = ok, 1 = R1 timeout, 2 = busy timeout, 3 = R1 illegal-command (bit2 set)
spi_start  out  1  one-cycle byte-start strobe
spi_mosi  out  8  byte to send, stable from spi_start to spi_done
spi_busy  in  1  byte engine busy
spi_done  in  1  one-cycle pulse, spi_miso valid
spi_miso  in  8  received byte
sd_cs_n  out  1  card select

Behaviour:
- Reset (asynchronous): state IDLE, sd_cs_n=1, spi_start=0, spi_mosi=8'hFF, cmd_ready=1, rsp_valid=0, rsp_r1=8'hFF, rsp_data=0, rsp_err=0.
- Byte rule: exactly one byte in flight. spi_start is asserted for one cycle only when !spi_busy && !spi_done and no byte is outstanding. The next start is issued no earlier than the cycle after spi_done.
- IDLE: cmd_ready=1. On accept, latch all cmd_* fields, drop cmd_ready, and compute CRC7 (poly x^7+x^3+1, 40 bits, MSB first) into crc byte = {crc7,1'b1}. sd_cs_n<=0, then go to PRE.
- PRE: send one 0xFF with CS low (Nrc/sync), then go to SEND.
- SEND: 6 bytes in order: {01,idx}, arg[31:24] .. arg[7:0], crc. After the 6th spi_done, go to POLL with counter=0.
- POLL: send 0xFF per byte. On spi_done with miso[7]==0, latch rsp_r1:
  - if miso[2]=1, set err=3 and go to FIN;
  - else if rtype=2, go to EXT;
  - else if rtype=1, go to BUSY;
  - else go to FIN.
  - If counter reaches NCR_MAX with no R1, set err=1, rsp_r1=FF, go to FIN.
- EXT: 4 bytes shifted into rsp_data MSB first, then go to FIN.
- BUSY: send 0xFF until a received byte != 8'h00, then go to FIN. After BUSY_MAX bytes, set err=2 and go to FIN.
- FIN: if hold_cs, go to DONE with CS low. Else sd_cs_n<=1 and go to GAP.
- GAP: send GAP_BYTES 0xFF bytes with CS high, then go to DONE. With GAP_BYTES=0, go straight to DONE.
- DONE: pulse rsp_valid for 1 cycle, assert cmd_ready next cycle, return to IDLE. Outputs rsp_* hold until the next accept.
- cmd_valid while busy is ignored (not queued). An accept in the same cycle as rsp_valid is impossible (ready=0).
- Counters saturate and do not wrap; the NCR counter counts 1..NCR_MAX inclusive.
- A spurious spi_done with no byte outstanding is ignored.
- Reset mid-command: CS releases immediately, no rsp_valid; the caller re-initializes the card.

Test Plan:
- CMD0 arg 0, rtype 0; card model returns FF,FF,01 -> MOSI FF,40,00,00,00,00,95, then 3 poll FFs; rsp_r1=01, err=0, CS high, 1 gap byte, single rsp_valid.
- CMD8 arg 000001AA, rtype 2; card returns 01,00,00,01,AA -> MOSI crc byte 87; rsp_data=000001AA, err=0. Repeat with CMD55 (crc 65), ACMD41 arg 40000000 (crc 77), CMD58 (crc FD) and CMD16 arg 200 (crc 15).
- CMD8 with card returning 05 -> err=3, no EXT bytes clocked, rsp_data=0.
- Card never answers (all FF), NCR_MAX=16 -> exactly 16 poll bytes, err=1, rsp_r1=FF, CS high.
- R1b CMD12: R1=00, then 00 x20, then FF -> exactly 21 busy bytes, err=0. With BUSY_MAX=8 -> err=2 after 8 bytes.
- hold_cs=1 CMD17 -> CS stays low after rsp_valid. Assert rst_n=0 mid-SEND -> CS=1 and spi_start=0 asynchronously, cmd_ready=1 after release, no rsp_valid.
